// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch stage: datapath width, instruction size,
// reset PC and the {pc, instr} entry carried from fetch to decode.
package pipe_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous flush; storage is cleared on reset.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes when full and pops when empty are ignored; callers gate on full/empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign push_ok  = push & !full;
    assign pop_ok   = pop & !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues in-order imem requests from curr_pc and steers nxt_pc.
// Latency: request at t, response at t+k (k>=1), instruction offered to decode at t+k+1.
// Backpressure: issue stops once buffered + outstanding reaches BUF_DEPTH; redirect stalls issue one cycle.
module fetch_ctrl
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] curr_pc,
    output logic [XLEN-1:0] nxt_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   buf_count;
    logic [CW-1:0]   pend_count;
    logic            buf_empty;
    logic            buf_full;
    logic            pend_empty;
    logic            pend_full;
    logic [XLEN-1:0] pend_pc;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_head;

    logic req_fire;
    logic rsp_fire;
    logic pop_fire;
    logic live_rsp;

    assign imem_req_valid = !reset && !redirect_valid &&
                            ((32'(buf_count) + 32'(outstanding)) < BUF_DEPTH);
    assign imem_req_addr  = curr_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_fire       = imem_rsp_valid;

    // Responses to requests made before a redirect are stale and never reach the buffer.
    assign live_rsp = rsp_fire && (drop_cnt == '0) && !redirect_valid;

    assign if_valid = !buf_empty && !redirect_valid;
    assign pop_fire = if_valid & id_ready;
    assign if_pc    = buf_head.pc;
    assign if_instr = buf_head.instr;
    assign buf_in   = '{pc: pend_pc, instr: imem_rsp_data};

    always_comb begin
        nxt_pc = curr_pc;
        if (reset) begin
            nxt_pc = RESET_PC;
        end else if (redirect_valid) begin
            nxt_pc = align_pc(redirect_pc);
        end else if (req_fire) begin
            nxt_pc = curr_pc + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({req_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - CW'(rsp_fire);
        end else if (rsp_fire && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Holds only live requests: flushed on redirect, so stale responses must not pop it.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_pend (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (req_fire),
        .push_dat (curr_pc),
        .pop      (live_rsp),
        .head_dat (pend_pc),
        .count    (pend_count),
        .empty    (pend_empty),
        .full     (pend_full)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_ibuf (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (live_rsp),
        .push_dat (buf_in),
        .pop      (pop_fire),
        .head_dat (buf_head),
        .count    (buf_count),
        .empty    (buf_empty),
        .full     (buf_full)
    );

    a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outstanding != '0));
    a_live_has_pc: assert property (@(posedge clk) disable iff (reset)
        live_rsp |-> (!pend_empty && !buf_full));
    a_pend_no_overflow: assert property (@(posedge clk) disable iff (reset)
        req_fire |-> !pend_full);
    a_pend_tracks_live: assert property (@(posedge clk) disable iff (reset)
        pend_count == (outstanding - drop_cnt));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the PC register and an in-order fixed-latency
// instruction memory returning 0x13 + addr, and records every instruction decode consumes.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] curr_pc = 32'h0;
    logic [31:0] nxt_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t  got[$];
    mreq_t memq[$];
    int    cyc     = 0;
    int    mem_lat = 1;
    int    checks  = 0;
    int    errors  = 0;

    fetch_ctrl #(
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .curr_pc        (curr_pc),
        .nxt_pc         (nxt_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    // PC register: loads nxt_pc on every edge.
    always @(posedge clk) curr_pc <= nxt_pc;

    // One clock cycle: sample handshakes, cross the edge, present the memory response.
    task automatic tick();
        mreq_t m;
        ent_t  e;
        #1;
        if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + mem_lat;
            memq.push_back(m);
        end
        if (imem_rsp_valid) void'(memq.pop_front());
        if (if_valid && id_ready) begin
            e.pc    = if_pc;
            e.instr = if_instr;
            got.push_back(e);
        end
        @(negedge clk);
        cyc++;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'h13 + memq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        memq.delete();
        repeat (3) tick();
        reset = 1'b0;
        got.delete();
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        repeat (3) tick();
        checks++; if (nxt_pc !== 32'h0) begin errors++; $display("FAIL reset_nxt_pc: got %h expected %h", nxt_pc, 32'h0); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h expected 0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h expected 0", if_instr); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
        reset = 1'b0;
        got.delete();
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL release_req_addr: got %h expected 0", imem_req_addr); end
        checks++; if (nxt_pc !== 32'h4) begin errors++; $display("FAIL release_nxt_pc: got %h expected 4", nxt_pc); end
    endtask

    task automatic test_straight_line();
        mem_lat = 1;
        for (int i = 0; i < 40 && got.size() < 4; i++) tick();
        checks++;
        if (got.size() < 4) begin
            errors++; $display("FAIL straight_timeout: got %0d instrs expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got[i].pc !== 32'(4 * i)) begin errors++; $display("FAIL straight_pc[%0d]: got %h expected %h", i, got[i].pc, 32'(4 * i)); end
                checks++; if (got[i].instr !== 32'(4 * i + 'h13)) begin errors++; $display("FAIL straight_instr[%0d]: got %h expected %h", i, got[i].instr, 32'(4 * i + 'h13)); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        do_reset();
        mem_lat  = 1;
        id_ready = 1'b0;
        repeat (10) tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=0", if_valid, if_pc); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (nxt_pc !== 32'h8) begin errors++; $display("FAIL bp_nxt_pc: got %h expected 8", nxt_pc); end
        checks++; if (dut.buf_count !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d expected 2", dut.buf_count); end
        checks++; if (dut.outstanding !== 2'd0) begin errors++; $display("FAIL bp_outstanding: got %0d expected 0", dut.outstanding); end
        id_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 40 && got.size() < 3; i++) tick();
        checks++;
        if (got.size() < 3) begin
            errors++; $display("FAIL bp_drain_timeout: got %0d instrs expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got[i].pc !== exp_pc[i] || got[i].instr !== exp_pc[i] + 32'h13) begin errors++; $display("FAIL bp_drain[%0d]: got pc=%h instr=%h expected pc=%h", i, got[i].pc, got[i].instr, exp_pc[i]); end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        mem_lat        = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        checks++; if (dut.outstanding !== 2'd2) begin errors++; $display("FAIL rd_outstanding: got %0d expected 2", dut.outstanding); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        checks++; if (nxt_pc !== 32'h200) begin errors++; $display("FAIL rd_nxt_pc: got %h expected 200", nxt_pc); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_req_valid: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (curr_pc !== 32'h200) begin errors++; $display("FAIL rd_curr_pc: got %h expected 200", curr_pc); end
        checks++; if (dut.drop_cnt !== 2'd2) begin errors++; $display("FAIL rd_drop_cnt: got %0d expected 2", dut.drop_cnt); end
        for (int i = 0; i < 40 && got.size() < 2; i++) tick();
        checks++;
        if (got.size() < 2) begin
            errors++; $display("FAIL rd_timeout: got %0d instrs expected 2", got.size());
        end else begin
            checks++; if (got[0].pc !== 32'h200 || got[0].instr !== 32'h213) begin errors++; $display("FAIL rd_first: got pc=%h instr=%h expected pc=200 instr=213", got[0].pc, got[0].instr); end
            checks++; if (got[1].pc !== 32'h204 || got[1].instr !== 32'h217) begin errors++; $display("FAIL rd_second: got pc=%h instr=%h expected pc=204 instr=217", got[1].pc, got[1].instr); end
        end
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        mem_lat = 1;
        repeat (2) tick();
        checks++; if (imem_rsp_valid !== 1'b1 || if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL co_setup: got rsp=%b valid=%b pc=%h expected rsp=1 valid=1 pc=0", imem_rsp_valid, if_valid, if_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL co_if_valid: got %b expected 0", if_valid); end
        checks++; if (nxt_pc !== 32'h100) begin errors++; $display("FAIL co_nxt_pc: got %h expected 100", nxt_pc); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL co_no_pop: got %0d pops expected 0", got.size()); end
        checks++; if (dut.buf_count !== 2'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL co_buf_empty: got count=%0d valid=%b expected 0", dut.buf_count, if_valid); end
        checks++; if (dut.drop_cnt !== 2'd0 || dut.outstanding !== 2'd0) begin errors++; $display("FAIL co_drop: got drop=%0d out=%0d expected 0 0", dut.drop_cnt, dut.outstanding); end
        for (int i = 0; i < 40 && got.size() < 2; i++) tick();
        checks++;
        if (got.size() < 2) begin
            errors++; $display("FAIL co_timeout: got %0d instrs expected 2", got.size());
        end else begin
            checks++; if (got[0].pc !== 32'h100 || got[1].pc !== 32'h104) begin errors++; $display("FAIL co_order: got %h %h expected 100 104", got[0].pc, got[1].pc); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got valid=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_req_addr); end
        checks++; if (nxt_pc !== 32'h0) begin errors++; $display("FAIL wrap_nxt_pc: got %h expected 0", nxt_pc); end
        for (int i = 0; i < 40 && got.size() < 2; i++) tick();
        checks++;
        if (got.size() < 2) begin
            errors++; $display("FAIL wrap_timeout: got %0d instrs expected 2", got.size());
        end else begin
            checks++; if (got[0].pc !== 32'hFFFF_FFFC || got[0].instr !== 32'h0000_000F) begin errors++; $display("FAIL wrap_first: got pc=%h instr=%h expected fffffffc 0000000f", got[0].pc, got[0].instr); end
            checks++; if (got[1].pc !== 32'h0 || got[1].instr !== 32'h13) begin errors++; $display("FAIL wrap_second: got pc=%h instr=%h expected 0 13", got[1].pc, got[1].instr); end
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
